// File: rtl/mac_tcdm_mux_pkg.sv
// Shared constants for the TCDM port funnel.
// No logic, no latency.
// No flow control of its own.
package mac_tcdm_mux_pkg;

  localparam int unsigned MAC_TCDM_MUX_MAX_IN = 8;

  localparam int unsigned TCDM_AW = 32;
  localparam int unsigned TCDM_DW = 32;
  localparam int unsigned TCDM_BW = 4;

endpackage

// File: rtl/mac_tcdm_mux_if.sv
// TCDM load/store port: request phase (req/gnt) plus in-order response (r_valid).
// No latency; pure wiring bundle.
// Backpressure is the req/gnt handshake; responses cannot be stalled.
interface hwpe_stream_intf_tcdm;
  import mac_tcdm_mux_pkg::*;

  logic               req;
  logic               gnt;
  logic [TCDM_AW-1:0] add;
  logic               wen;
  logic [TCDM_BW-1:0] be;
  logic [TCDM_DW-1:0] data;
  logic [TCDM_DW-1:0] r_data;
  logic               r_valid;

  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data,
    output gnt, r_data, r_valid
  );

endinterface

// File: rtl/mac_tcdm_mux_id_fifo.sv
// In-order FIFO of port IDs for granted-but-unanswered transactions.
// Head is registered state; push visible at head one cycle later.
// Push is dropped when full unless a pop frees the slot in the same cycle.
module mac_tcdm_mux_id_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign head    = mem[rd_ptr];

  // Storage is data only; validity is tracked by count, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_tcdm_mux.sv
// Funnels NB_IN TCDM master ports onto one; round-robin with lock while waiting for gnt.
// Zero latency on request, grant and response paths (response steered by registered ID FIFO head).
// Downstream gnt is forwarded to the selected port only; requests stall while the ID FIFO is full.
module mac_tcdm_mux
  import mac_tcdm_mux_pkg::*;
#(
  parameter int unsigned NB_IN         = 4,
  parameter int unsigned ID_FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  hwpe_stream_intf_tcdm.slave  tcdm_slave [NB_IN-1:0],
  hwpe_stream_intf_tcdm.master tcdm_master,
  output logic                 busy_o
);

  localparam int unsigned ID_W = $clog2(NB_IN);

  logic [NB_IN-1:0]   s_req;
  logic [NB_IN-1:0]   s_wen;
  logic [TCDM_AW-1:0] s_add  [NB_IN];
  logic [TCDM_BW-1:0] s_be   [NB_IN];
  logic [TCDM_DW-1:0] s_data [NB_IN];

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] arb_sel;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] lock_idx;
  logic [ID_W-1:0] head;
  logic            lock;
  logic            fifo_full;
  logic            fifo_empty;
  logic            m_req;
  logic            hs;
  logic            rsp_ok;

  for (genvar k = 0; k < NB_IN; k++) begin : g_port
    assign s_req[k]  = tcdm_slave[k].req;
    assign s_wen[k]  = tcdm_slave[k].wen;
    assign s_add[k]  = tcdm_slave[k].add;
    assign s_be[k]   = tcdm_slave[k].be;
    assign s_data[k] = tcdm_slave[k].data;

    assign tcdm_slave[k].gnt     = hs && (sel == ID_W'(k));
    assign tcdm_slave[k].r_valid = rsp_ok && (head == ID_W'(k));
    assign tcdm_slave[k].r_data  = tcdm_master.r_data;
  end

  // First requester at or after rr_ptr, searching cyclically upward.
  always_comb begin
    logic        found;
    int unsigned idx;
    arb_sel = rr_ptr;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NB_IN; i++) begin
      idx = (32'(rr_ptr) + i) % NB_IN;
      if (!found && s_req[ID_W'(idx)]) begin
        found   = 1'b1;
        arb_sel = ID_W'(idx);
      end
    end
  end

  assign sel    = lock ? lock_idx : arb_sel;
  assign m_req  = s_req[sel] && !fifo_full;
  assign hs     = m_req && tcdm_master.gnt;
  assign rsp_ok = tcdm_master.r_valid && !fifo_empty;
  assign busy_o = !fifo_empty || (|s_req);

  assign tcdm_master.req  = m_req;
  assign tcdm_master.add  = s_add[sel];
  assign tcdm_master.wen  = s_wen[sel];
  assign tcdm_master.be   = s_be[sel];
  assign tcdm_master.data = s_data[sel];

  // Round-robin pointer moves past each granted port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      rr_ptr <= '0;
    else if (clear_i) rr_ptr <= '0;
    else if (hs)      rr_ptr <= (sel == ID_W'(NB_IN-1)) ? '0 : sel + ID_W'(1);
  end

  // Freeze the selection while a presented request waits for gnt.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (clear_i) begin
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (hs) begin
      lock     <= 1'b0;
    end else if (m_req) begin
      lock     <= 1'b1;
      lock_idx <= sel;
    end
  end

  mac_tcdm_mux_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (ID_FIFO_DEPTH)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push    (hs),
    .din     (sel),
    .pop     (rsp_ok),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Responses with nothing outstanding are dropped; flag them, and a bad port count.
  always_ff @(posedge clk_i) begin
    assert (NB_IN >= 2 && NB_IN <= MAC_TCDM_MUX_MAX_IN)
      else $error("mac_tcdm_mux: NB_IN out of range");
    if (rst_ni && !clear_i && tcdm_master.r_valid)
      assert (!fifo_empty)
        else $warning("mac_tcdm_mux: r_valid with no outstanding transaction, dropped");
  end

endmodule

// File: tb/tb_mac_tcdm_mux.sv
// Directed bench for mac_tcdm_mux: reset, single port, round-robin, lock, FIFO full, mixed latency, clear/reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Downstream gnt/r_valid are driven directly as a scripted memory.
module tb_mac_tcdm_mux;

  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic busy;

  logic [NB-1:0] t_req;
  logic [NB-1:0] t_wen;
  logic [31:0]   t_add  [NB];
  logic [31:0]   t_data [NB];
  logic [3:0]    t_be   [NB];
  logic [NB-1:0] o_gnt;
  logic [NB-1:0] o_rv;
  logic [31:0]   o_rdata [NB];

  logic        m_gnt;
  logic        m_rv;
  logic [31:0] m_rdata;

  int errors = 0;
  int checks = 0;

  // Mixed-latency table: requesting port, its wen, response this cycle, port expected to get it.
  int t5_port [6] = '{3, 0, 1, -1, -1, -1};
  bit t5_wen  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  bit t5_rv   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int t5_rsp  [6] = '{-1, 3, -1, 0, -1, 1};

  hwpe_stream_intf_tcdm slv [NB-1:0] ();
  hwpe_stream_intf_tcdm mst ();

  for (genvar g = 0; g < NB; g++) begin : g_slv
    assign slv[g].req  = t_req[g];
    assign slv[g].wen  = t_wen[g];
    assign slv[g].add  = t_add[g];
    assign slv[g].data = t_data[g];
    assign slv[g].be   = t_be[g];
    assign o_gnt[g]    = slv[g].gnt;
    assign o_rv[g]     = slv[g].r_valid;
    assign o_rdata[g]  = slv[g].r_data;
  end

  assign mst.gnt     = m_gnt;
  assign mst.r_valid = m_rv;
  assign mst.r_data  = m_rdata;

  mac_tcdm_mux #(
    .NB_IN         (NB),
    .ID_FIFO_DEPTH (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .tcdm_slave  (slv),
    .tcdm_master (mst),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [NB-1:0] req, input logic gnt, input logic rv, input logic [31:0] rdata);
    t_req   = req;
    m_gnt   = gnt;
    m_rv    = rv;
    m_rdata = rdata;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    drive('0, 1'b0, 1'b0, 32'h0);
    t_wen = '1;
    for (int k = 0; k < NB; k++) begin
      t_add[k]  = 32'h1000 + 32'(4 * k);
      t_data[k] = 32'h1111_1111 * 32'(k + 1);
      t_be[k]   = 4'hF;
    end

    // Reset state
    #2;
    check_val("rst_gnt", 32'(o_gnt), 32'h0);
    check_val("rst_rv", 32'(o_rv), 32'h0);
    check_val("rst_req", 32'(mst.req), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    t_req = 4'b0010;
    #1;
    check_val("rst_req_pass", 32'(mst.req), 32'h1);
    check_val("rst_busy_req", 32'(busy), 32'h1);
    t_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // Single port load
    t_add[2] = 32'h100;
    drive(4'b0100, 1'b1, 1'b0, 32'h0);
    settle();
    check_val("t1_req", 32'(mst.req), 32'h1);
    check_val("t1_add", mst.add, 32'h100);
    check_val("t1_gnt", 32'(o_gnt), 32'h4);
    check_val("t1_rv0", 32'(o_rv), 32'h0);
    next_cycle();
    drive('0, 1'b0, 1'b1, 32'hCAFE_0001);
    settle();
    check_val("t1_rv", 32'(o_rv), 32'h4);
    check_val("t1_rdata", o_rdata[2], 32'hCAFE_0001);
    check_val("t1_gnt_off", 32'(o_gnt), 32'h0);
    next_cycle();
    drive('0, 1'b0, 1'b0, 32'h0);
    settle();
    check_val("t1_busy", 32'(busy), 32'h0);
    t_add[2] = 32'h1008;

    // Round-robin after clear (clear returns rr_ptr to 0)
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      drive((c < 8) ? 4'hF : 4'h0, c < 8, c > 0, 32'hD000_0000 + 32'(c - 1));
      settle();
      if (c < 8) begin
        check_val("t2_gnt", 32'(o_gnt), 32'h1 << (c % 4));
        check_val("t2_add", mst.add, 32'h1000 + 32'(4 * (c % 4)));
      end
      if (c > 0) begin
        check_val("t2_rv", 32'(o_rv), 32'h1 << ((c - 1) % 4));
        check_val("t2_rdata", o_rdata[(c - 1) % 4], 32'hD000_0000 + 32'(c - 1));
      end
      next_cycle();
    end

    // Lock: port 1 held while port 0 joins during the wait
    for (int c = 0; c < 3; c++) begin
      drive((c == 0) ? 4'b1010 : 4'b1011, 1'b0, 1'b0, 32'h0);
      settle();
      check_val("t3_add_wait", mst.add, 32'h1004);
      check_val("t3_data_wait", mst.data, 32'h2222_2222);
      check_val("t3_gnt_wait", 32'(o_gnt), 32'h0);
      next_cycle();
    end
    drive(4'b1011, 1'b1, 1'b0, 32'h0);
    settle();
    check_val("t3_gnt_p1", 32'(o_gnt), 32'h2);
    check_val("t3_add_p1", mst.add, 32'h1004);
    next_cycle();
    drive(4'b1001, 1'b1, 1'b0, 32'h0);
    settle();
    check_val("t3_gnt_p3", 32'(o_gnt), 32'h8);
    check_val("t3_add_p3", mst.add, 32'h100C);
    next_cycle();
    drive(4'b0001, 1'b1, 1'b0, 32'h0);
    settle();
    check_val("t3_gnt_p0", 32'(o_gnt), 32'h1);
    next_cycle();
    drive('0, 1'b0, 1'b1, 32'hB000_0001);
    settle();
    check_val("t3_rv_p1", 32'(o_rv), 32'h2);
    check_val("t3_rdata_p1", o_rdata[1], 32'hB000_0001);
    next_cycle();
    drive('0, 1'b0, 1'b1, 32'hB000_0003);
    settle();
    check_val("t3_rv_p3", 32'(o_rv), 32'h8);
    next_cycle();
    drive('0, 1'b0, 1'b1, 32'hB000_0000);
    settle();
    check_val("t3_rv_p0", 32'(o_rv), 32'h1);
    next_cycle();

    // FIFO full: rr_ptr is 1, so grants go 1,2,3,0 then stall
    for (int c = 0; c < 4; c++) begin
      drive(4'hF, 1'b1, 1'b0, 32'h0);
      settle();
      check_val("t4_gnt", 32'(o_gnt), 32'h1 << ((c + 1) % 4));
      next_cycle();
    end
    settle();
    check_val("t4_full_req", 32'(mst.req), 32'h0);
    check_val("t4_full_gnt", 32'(o_gnt), 32'h0);
    check_val("t4_full_busy", 32'(busy), 32'h1);
    next_cycle();
    drive(4'hF, 1'b1, 1'b1, 32'hE000_0001);
    settle();
    check_val("t4_pop_rv", 32'(o_rv), 32'h2);
    check_val("t4_pop_req", 32'(mst.req), 32'h0);
    next_cycle();
    drive(4'hF, 1'b1, 1'b0, 32'h0);
    settle();
    check_val("t4_regrant", 32'(o_gnt), 32'h2);
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      drive('0, 1'b0, 1'b1, 32'hE000_0010 + 32'(c));
      settle();
      check_val("t4_drain_rv", 32'(o_rv), 32'h1 << ((c + 2) % 4));
      next_cycle();
    end

    // Store/load interleave with response latencies 1, 2, 3
    for (int c = 0; c < 6; c++) begin
      logic [NB-1:0] r;
      r = '0;
      if (t5_port[c] >= 0) begin
        r = 4'(1) << t5_port[c];
        t_wen[t5_port[c]] = t5_wen[c];
      end
      drive(r, t5_port[c] >= 0, t5_rv[c], 32'hA000_0000 + 32'(c));
      settle();
      check_val("t5_gnt", 32'(o_gnt), 32'(r));
      if (t5_port[c] >= 0) check_val("t5_wen", 32'(mst.wen), 32'(t5_wen[c]));
      check_val("t5_rv", 32'(o_rv), (t5_rsp[c] >= 0) ? (32'h1 << t5_rsp[c]) : 32'h0);
      if (t5_rsp[c] >= 0) check_val("t5_rdata", o_rdata[t5_rsp[c]], 32'hA000_0000 + 32'(c));
      next_cycle();
    end
    t_wen = '1;

    // Clear with two outstanding transactions
    drive(4'b1000, 1'b1, 1'b0, 32'h0);
    settle();
    check_val("t6_gnt_p3", 32'(o_gnt), 32'h8);
    next_cycle();
    drive(4'b0010, 1'b1, 1'b0, 32'h0);
    settle();
    check_val("t6_gnt_p1", 32'(o_gnt), 32'h2);
    next_cycle();
    drive('0, 1'b0, 1'b0, 32'h0);
    clear = 1'b1;
    settle();
    check_val("t6_busy_pre", 32'(busy), 32'h1);
    next_cycle();
    clear = 1'b0;
    settle();
    check_val("t6_busy_post", 32'(busy), 32'h0);
    next_cycle();
    drive('0, 1'b0, 1'b1, 32'h0BAD_0BAD);
    settle();
    check_val("t6_late_rv", 32'(o_rv), 32'h0);
    next_cycle();
    drive(4'b0101, 1'b0, 1'b0, 32'h0);
    settle();
    check_val("t6_rr_reset_add", mst.add, 32'h1000);
    next_cycle();
    drive(4'b0101, 1'b1, 1'b0, 32'h0);
    settle();
    check_val("t6_gnt_p0", 32'(o_gnt), 32'h1);
    next_cycle();
    drive(4'b0100, 1'b0, 1'b0, 32'h0);
    settle();
    check_val("t6_wait_req", 32'(mst.req), 32'h1);
    next_cycle();

    // Asynchronous reset mid-cycle: port 0 response outstanding, port 2 locked
    drive('0, 1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t7_busy", 32'(busy), 32'h0);
    check_val("t7_req", 32'(mst.req), 32'h0);
    m_rv = 1'b1;
    #1;
    check_val("t7_rv_in_rst", 32'(o_rv), 32'h0);
    m_rv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    drive('0, 1'b0, 1'b1, 32'h0BAD_0002);
    settle();
    check_val("t7_late_rv", 32'(o_rv), 32'h0);
    next_cycle();
    drive(4'b0010, 1'b1, 1'b0, 32'h0);
    settle();
    check_val("t7_gnt_p1", 32'(o_gnt), 32'h2);
    next_cycle();
    drive('0, 1'b0, 1'b1, 32'h5A5A_5A5A);
    settle();
    check_val("t7_rv_p1", 32'(o_rv), 32'h2);
    check_val("t7_rdata_p1", o_rdata[1], 32'h5A5A_5A5A);
    next_cycle();
    drive('0, 1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
